bcd_serial_adder: RTL and testbench



---
 rtl/bcd_serial_adder_pkg.sv | 27 ++
 rtl/bcd_digit_add.sv | 21 ++
 rtl/bcd_serial_adder.sv | 122 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// bcd_serial_adder_pkg: shared constants, FSM state type and BCD digit helpers
// Contents:
//   DIGIT_W    - bits per BCD digit
//   DIGITS_DEF - default operand width in digits
//   state_t    - IDLE / RUN / DONE encodings
//   nines      - nine's complement of one digit
//   is_bad     - digit outside 0..9
package bcd_serial_adder_pkg;

    localparam int DIGIT_W    = 4;
    localparam int DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    function automatic logic is_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with +6 decimal correction
// Ports:
//   a_i, b_i - BCD digits
//   ci_i     - decimal carry in
//   s_o      - corrected BCD sum digit
//   co_o     - decimal carry out
module bcd_digit_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [4:0] raw;

    assign raw  = {1'b0, a_i} + {1'b0, b_i} + {4'd0, ci_i};
    assign co_o = raw > 5'd9;
    assign s_o  = co_o ? raw[3:0] + 4'd6 : raw[3:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial multi-digit BCD adder/subtractor with start/busy/done handshake
// Ports:
//   clk_i, reset_i - clock, asynchronous active-high reset
//   start_i        - request, accepted in IDLE or DONE
//   sub_i, cin_i   - subtract mode, decimal carry in (add only)
//   a_i, b_i       - operands, digit i at [4i+3:4i]
//   sum_o, cout_o  - result digits, carry out (sub: 1 = no borrow)
//   invalid_o      - a latched operand digit was >9
//   busy_o, done_o - running, one-cycle result-valid pulse
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    sub_i,
    input  logic                    cin_i,
    input  logic [DIGIT_W*DIGITS-1:0] a_i,
    input  logic [DIGIT_W*DIGITS-1:0] b_i,
    output logic [DIGIT_W*DIGITS-1:0] sum_o,
    output logic                    cout_o,
    output logic                    invalid_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, inv_q, inv_d;
    logic [3:0]      y, s;
    logic            co, bad, last;

    // Operands shift right each step so the current digit is always at [3:0]
    assign y    = sub_q ? nines(b_q[3:0]) : b_q[3:0];
    assign last = cnt_q == CW'(DIGITS - 1);

    bcd_digit_add u_cell (
        .a_i  (a_q[3:0]),
        .b_i  (y),
        .ci_i (carry_q),
        .s_o  (s),
        .co_o (co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        bad     = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | is_bad(a_i[4*i +: 4]) | is_bad(b_i[4*i +: 4]);
        if (state_q == RUN) begin
            a_d     = a_q >> DIGIT_W;
            b_d     = b_q >> DIGIT_W;
            carry_d = co;
            cnt_d   = cnt_q + 1'b1;
            // Invalid operations write zero digits so sum reads 0 at done
            for (int i = 0; i < DIGITS; i++)
                if (cnt_q == i[CW-1:0])
                    sum_d[4*i +: 4] = inv_q ? 4'd0 : s;
            if (last) begin
                state_d = DONE;
                cout_d  = co & ~inv_q;
            end
        end
        if (start_i && state_q != RUN) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = a_i;
            b_d     = b_i;
            sub_d   = sub_i;
            // Subtraction is a + nines(b) + 1
            carry_d = sub_i | cin_i;
            inv_d   = bad;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
        end
    end

    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign invalid_o = inv_q;
    assign busy_o    = state_q == RUN;
    assign done_o    = state_q == DONE;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed self-checking bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;

    logic        clk, rst, start, sub, cin;
    logic [15:0] a, b, sum;
    logic        cout, invalid, busy, done;
    int          n_checks, n_fail, lat;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .start_i   (start),
        .sub_i     (sub),
        .cin_i     (cin),
        .a_i       (a),
        .b_i       (b),
        .sum_o     (sum),
        .cout_o    (cout),
        .invalid_o (invalid),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts negedges until done, returning -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv, output int n);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        wait_done(n);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_inv", invalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        op(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
        check("add_lat", lat, 4);
        check("add_sum", sum, 16'h6912);
        check("add_cout", cout, 0);
        check("add_inv", invalid, 0);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);

        op(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
        check("wrap_sum", sum, 16'h0000);
        check("wrap_cout", cout, 1);

        op(16'h0999, 16'h0000, 1'b0, 1'b1, lat);
        check("cin_sum", sum, 16'h1000);
        check("cin_cout", cout, 0);

        op(16'h12A4, 16'h0001, 1'b0, 1'b0, lat);
        check("inv_lat", lat, 4);
        check("inv_flag", invalid, 1);
        check("inv_sum", sum, 0);
        check("inv_cout", cout, 0);

        op(16'h5000, 16'h1234, 1'b1, 1'b1, lat);
        check("sub_sum", sum, 16'h3766);
        check("sub_cout", cout, 1);
        check("sub_inv", invalid, 0);

        op(16'h1234, 16'h5000, 1'b1, 1'b0, lat);
        check("neg_sum", sum, 16'h6234);
        check("neg_cout", cout, 0);

        // Start pulse during RUN must be ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h9999; b = 16'h9999;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 2);
        check("ign_sum", sum, 16'h3333);
        check("ign_cout", cout, 0);

        // Start held through DONE restarts immediately
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        check("b2b_lat1", lat, 4);
        check("b2b_sum1", sum, 16'h0003);
        a = 16'h0005; b = 16'h0005;
        wait_done(lat);
        start = 1'b0;
        check("b2b_period", lat, 5);
        check("b2b_sum2", sum, 16'h0010);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_sum", sum, 16'h0045);
        check("mid_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_sum", sum, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 0);
        op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        check("post_lat", lat, 4);
        check("post_sum", sum, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
